// File: rtl/seed_dispatch_queue.sv
// clk1-side seed front end: FIFO of tagged seed requests feeding the clk1->clk2
// handshake synchroniser one transfer at a time, with zero-seed fix and drop accounting.
module seed_dispatch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                CH_W     = 2,
  parameter int                MODE_W   = 2,
  parameter int                GAP_CYC  = 1,
  parameter logic [DATA_W-1:0] ZERO_SUB = DATA_W'(1)
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             seed,
  input  logic [CH_W-1:0]               in_ch,
  input  logic [MODE_W-1:0]             in_mode,
  output logic                          hs_valid,
  output logic [DATA_W+CH_W+MODE_W-1:0] hs_data,
  input  logic                          hs_done_src,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          ovf,
  input  logic                          clr_ovf,
  output logic [7:0]                    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + CH_W + MODE_W;
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  // Degenerate all-zero xorshift seed is replaced when the entry's mode[0] asks for it.
  function automatic logic [EW-1:0] zero_fix(input logic [EW-1:0] e);
    logic [DATA_W-1:0] s;
    logic [MODE_W-1:0] m;
    s = e[DATA_W-1:0];
    m = e[EW-1 -: MODE_W];
    if (m[0] && (s == '0)) s = ZERO_SUB;
    return {e[EW-1:DATA_W], s};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q, cnt_d;
  state_t        state_q;
  logic [3:0]    gap_q;
  logic          hs_valid_q;
  logic [EW-1:0] hs_data_q;
  logic          ovf_q;
  logic [7:0]    drop_q;

  logic full, push, pop, drop;

  assign full = (cnt_q == LW'(DEPTH));
  assign push = in_valid && !full;
  assign drop = in_valid && full;
  assign pop  = (state_q == S_IDLE) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; only occupancy and pointers decide what is valid.
  always_ff @(posedge clk1) begin
    if (push) mem_q[wr_q] <= {in_mode, in_ch, seed};
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      gap_q      <= '0;
      hs_valid_q <= 1'b0;
      hs_data_q  <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;

      if (clr_ovf) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else if (drop) begin
        ovf_q  <= 1'b1;
        drop_q <= sat_inc(drop_q);
      end

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            hs_data_q  <= zero_fix(mem_q[rd_q]);
            hs_valid_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (hs_done_src) begin
            hs_valid_q <= 1'b0;
            if (GAP_CYC > 0) begin
              gap_q   <= GAP_INIT;
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_q <= 4'd1) state_q <= S_IDLE;
          else               gap_q   <= gap_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = !full;
  assign hs_valid = hs_valid_q;
  assign hs_data  = hs_data_q;
  assign level    = cnt_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_seed_dispatch_queue.sv
// Scoreboard bench for seed_dispatch_queue: directed seeds, expected transfers queued
// at issue time and popped by a monitor on each rising hs_valid.
module tb_seed_dispatch_queue;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_n, rst3_n, in_valid, clr_ovf, hs_done_src;
  logic [31:0] seed;
  logic [1:0]  in_ch, in_mode;

  logic        in_ready, hs_valid, ovf;
  logic [35:0] hs_data;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;

  logic        in_ready3, hs_valid3, ovf3;
  logic [35:0] hs_data3;
  logic [2:0]  level3;
  logic [7:0]  drop_cnt3;

  seed_dispatch_queue #(.GAP_CYC(1)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .seed(seed), .in_ch(in_ch), .in_mode(in_mode), .hs_valid(hs_valid),
    .hs_data(hs_data), .hs_done_src(hs_done_src), .level(level), .ovf(ovf),
    .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  seed_dispatch_queue #(.GAP_CYC(3)) dut3 (
    .clk1(clk1), .rst_n(rst3_n), .in_valid(in_valid), .in_ready(in_ready3),
    .seed(seed), .in_ch(in_ch), .in_mode(in_mode), .hs_valid(hs_valid3),
    .hs_data(hs_data3), .hs_done_src(hs_done_src), .level(level3), .ovf(ovf3),
    .clr_ovf(clr_ovf), .drop_cnt(drop_cnt3)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Drives one request cycle; in_valid is left high so callers can stream back-to-back.
  task automatic send(input logic [31:0] s, input logic [1:0] c, input logic [1:0] m,
                      input logic [31:0] exp_seed, input logic acc);
    in_valid = 1'b1;
    seed     = s;
    in_ch    = c;
    in_mode  = m;
    chk("in_ready", in_ready, acc);
    if (acc) exp_q.push_back({m, c, exp_seed});
    tick();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!hs_valid && k < 30) begin
      tick();
      k++;
    end
    if (!hs_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout: got hs_valid=0 expected 1 within 30 cycles");
    end
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("done_drops_valid", hs_valid, 1'b0);
  endtask

  task automatic monitor();
    logic        prev;
    logic [35:0] held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk1);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (hs_valid && !prev) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_xfer: got %0h expected no transfer", hs_data);
          end else begin
            chk("xfer_data", hs_data, exp_q.pop_front());
          end
          held = hs_data;
        end else if (hs_valid && prev) begin
          chk("hs_data_stable", hs_data, held);
        end
        prev = hs_valid;
      end
    end
  endtask

  initial begin
    int g1, g3;
    rst_n = 1'b0; rst3_n = 1'b0;
    in_valid = 1'b0; clr_ovf = 1'b0; hs_done_src = 1'b0;
    seed = '0; in_ch = '0; in_mode = '0;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_hs_valid", hs_valid, 1'b0);
    chk("rst_hs_data", hs_data, 36'h0);
    chk("rst_level", level, 3'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);
    rst_n = 1'b1;
    tick();

    // 1: single seed, one-cycle latency
    send(32'h1234_5678, 2'd1, 2'd0, 32'h1234_5678, 1'b1);
    in_valid = 1'b0;
    chk("t1_level_after_push", level, 3'd1);
    chk("t1_not_yet_valid", hs_valid, 1'b0);
    tick();
    chk("t1_valid_latency", hs_valid, 1'b1);
    chk("t1_hs_data", hs_data, 36'h1_1234_5678);
    chk("t1_level_after_pop", level, 3'd0);
    wait_done();
    tick(); tick();

    // 2: stream five seeds with done withheld
    send(32'hA000_0001, 2'd0, 2'd2, 32'hA000_0001, 1'b1);
    chk("t2_level0", level, 3'd1);
    send(32'hB000_0002, 2'd1, 2'd0, 32'hB000_0002, 1'b1);
    chk("t2_level1", level, 3'd1);
    send(32'hC000_0003, 2'd2, 2'd3, 32'hC000_0003, 1'b1);
    chk("t2_level2", level, 3'd2);
    send(32'hD000_0004, 2'd3, 2'd1, 32'hD000_0004, 1'b1);
    chk("t2_level3", level, 3'd3);
    send(32'hE000_0005, 2'd1, 2'd2, 32'hE000_0005, 1'b1);
    chk("t2_level_full", level, 3'd4);

    // 3: three requests against a full queue, then clear racing a fourth drop
    send(32'hF000_0006, 2'd0, 2'd0, 32'h0, 1'b0);
    send(32'hF000_0007, 2'd0, 2'd0, 32'h0, 1'b0);
    send(32'hF000_0008, 2'd0, 2'd0, 32'h0, 1'b0);
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_drop_cnt", drop_cnt, 8'd3);
    chk("t3_level_unchanged", level, 3'd4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf  = 1'b0;
    in_valid = 1'b0;
    chk("t3_clr_ovf", ovf, 1'b0);
    chk("t3_clr_drop_wins", drop_cnt, 8'd0);
    for (int i = 0; i < 5; i++) wait_done();
    tick(); tick(); tick();
    chk("t3_drained_level", level, 3'd0);
    chk("t3_drained_valid", hs_valid, 1'b0);

    // 4: zero-seed substitution
    send(32'h0, 2'd2, 2'b01, 32'h1, 1'b1);
    in_valid = 1'b0;
    wait_done();
    send(32'h0, 2'd3, 2'b00, 32'h0, 1'b1);
    in_valid = 1'b0;
    wait_done();
    send(32'h0, 2'd0, 2'b11, 32'h1, 1'b1);
    in_valid = 1'b0;
    wait_done();
    tick(); tick(); tick();

    // 5: inter-transfer gap for GAP_CYC=1 (dut) and GAP_CYC=3 (dut3)
    rst3_n = 1'b1;
    tick();
    send(32'h0000_0001, 2'd0, 2'd0, 32'h0000_0001, 1'b1);
    send(32'h0000_0002, 2'd1, 2'd0, 32'h0000_0002, 1'b1);
    in_valid = 1'b0;
    chk("t5_dut3_valid", hs_valid3, 1'b1);
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    g1 = 0;
    g3 = 0;
    for (int k = 1; k <= 12; k++) begin
      if (hs_valid  && g1 == 0) g1 = k;
      if (hs_valid3 && g3 == 0) g3 = k;
      if (g1 == 0 || g3 == 0) tick();
    end
    chk("t5_gap1_low_cycles", g1 - 1, 2);
    chk("t5_gap3_low_cycles", g3 - 1, 4);
    chk("t5_dut3_second_data", hs_data3, 36'h1_0000_0002);
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("t5_dut3_done", hs_valid3, 1'b0);
    tick(); tick(); tick();

    // 6: async reset mid-transfer with two seeds queued
    send(32'h5555_0001, 2'd1, 2'd1, 32'h5555_0001, 1'b1);
    send(32'h5555_0002, 2'd2, 2'd1, 32'h5555_0002, 1'b1);
    send(32'h5555_0003, 2'd3, 2'd1, 32'h5555_0003, 1'b1);
    in_valid = 1'b0;
    chk("t6_level_queued", level, 3'd2);
    chk("t6_in_flight", hs_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", hs_valid, 1'b0);
    chk("t6_async_level", level, 3'd0);
    chk("t6_async_in_ready", in_ready, 1'b1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t6_no_stale_valid", hs_valid, 1'b0);
    end
    chk("t6_level_after", level, 3'd0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
